// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - fetch-to-decode controller: 2-entry skid buffer, imm format decode, flush
// Optional feature macro: DECODE_ILLEGAL_EN (per-entry illegal-opcode flag).
module decode_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [INSTR_WIDTH-1:0] if_instr,
  input  logic [PC_WIDTH-1:0]    if_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [2:0]             imm_src,
  input  logic                   flush,
  output logic                   illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [2:0]             head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
  logic [2:0]             in_imm;
  logic                   in_fire, out_fire;
  logic                   load_head_in, load_head_skid, load_skid_in;

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  assign in_imm   = imm_decode(if_instr[6:0]);
  assign if_ready = (state_q != TWO);
  assign id_valid = (state_q != EMPTY) & ~flush;
  assign in_fire  = if_valid & if_ready & ~flush;
  assign out_fire = id_valid & id_ready;
  assign id_instr = head_instr_q;
  assign id_pc    = head_pc_q;
  assign imm_src  = head_imm_q;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin
        load_head_in = 1'b1;
        state_d      = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_head_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          load_skid_in = 1'b1;
          state_d      = TWO;
        end
      end
      TWO: if (out_fire) begin
        load_head_skid = 1'b1;
        state_d        = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins; in_fire is already gated so no entry is loaded this cycle.
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    head_imm_d   = head_imm_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_imm_d   = skid_imm_q;
    if (load_head_in) begin
      head_instr_d = if_instr;
      head_pc_d    = if_pc;
      head_imm_d   = in_imm;
    end else if (load_head_skid) begin
      head_instr_d = skid_instr_q;
      head_pc_d    = skid_pc_q;
      head_imm_d   = skid_imm_q;
    end
    if (load_skid_in) begin
      skid_instr_d = if_instr;
      skid_pc_d    = if_pc;
      skid_imm_d   = in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      head_imm_q   <= 3'b000;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= 3'b000;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      head_imm_q   <= head_imm_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_imm_q   <= skid_imm_d;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic head_ill_q, head_ill_d, skid_ill_q, skid_ill_d, in_ill;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign in_ill  = ~is_legal(if_instr[6:0]);
  assign illegal = head_ill_q;

  always_comb begin
    head_ill_d = head_ill_q;
    skid_ill_d = skid_ill_q;
    if (load_head_in)        head_ill_d = in_ill;
    else if (load_head_skid) head_ill_d = skid_ill_q;
    if (load_skid_in)        skid_ill_d = in_ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ill_q <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      head_ill_q <= head_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
